mdu_rs: RTL and testbench
=========================

MDU_RS -- requirements
Module: mdu_rs

Interface
REQ-001 Parameter DEPTH, default 4 (from `MDU_RS_DEPTH`), number of reservation-station entries; legal values 2..8.
REQ-002 clk  in  1  single clock, all state rising-edge.
REQ-003 rst_n  in  1  asynchronous reset, active-low.
REQ-004 flush  in  1  pipeline flush (mispredict), synchronous.
REQ-005 disp_valid_i  in  1  dispatch request for one M-extension op.
REQ-006 disp_op_i  in  5  ALU opcode (ALU_OP_MUL..ALU_OP_REMU).
REQ-007 disp_rob_id_i  in  ROB_ID_WIDTH  destination tag.
REQ-008 disp_vj_i / disp_vk_i  in  32 each  operand values, meaningful when the matching wait flag is 0.
REQ-009 disp_qj_wait_i / disp_qk_wait_i  in  1 each  operand pending on a producer tag.
REQ-010 disp_qj_i / disp_qk_i  in  ROB_ID_WIDTH each  producer tags.
REQ-011 disp_ready_o  out  1  at least one free entry.
REQ-012 cdb_valid_i  in  1; cdb_rob_id_i  in  ROB_ID_WIDTH; cdb_value_i  in  32: broadcast result snoop.
REQ-013 mdu_start_o  out  1; mdu_op_o  out  5; mdu_rs1_o / mdu_rs2_o  out  32; mdu_rob_id_o  out  ROB_ID_WIDTH: issue port to the MDU.
REQ-014 mdu_ready_i  in  1  MDU can accept an op this cycle.
REQ-015 count_o  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-016 Entries form a collapsing age queue: entry 0 is oldest, valid entries are contiguous from 0.
REQ-017 disp_ready_o SHALL be 1 iff count < DEPTH, independent of same-cycle issue (no full-and-issue pass-through).
REQ-018 Dispatch is accepted when disp_valid_i && disp_ready_o && !flush; the new entry is written at the lowest free slot after collapse.
REQ-019 An entry is ready when valid, !qj_wait, !qk_wait.
REQ-020 mdu_start_o SHALL be 1 (combinational) iff mdu_ready_i && !flush && any entry is ready; mdu_op_o/rs1/rs2/rob_id carry the lowest-index ready entry; outputs are zero when mdu_start_o is 0.
REQ-021 An issued entry is removed at the same edge; higher entries shift down one slot.
REQ-022 Wakeup: when cdb_valid_i and a waiting tag equals cdb_rob_id_i, the operand captures cdb_value_i and clears its wait flag at the edge; the entry is first issue-eligible the following cycle.
REQ-023 Dispatch bypass: if cdb_valid_i matches disp_qj_i/disp_qk_i (with wait set) in the dispatch cycle, the entry is written with the CDB value and wait cleared.
REQ-024 A newly dispatched entry is not issue-eligible in its dispatch cycle.
REQ-025 Simultaneous dispatch, issue and wakeup in one cycle SHALL all take effect; count changes by +1, 0 or -1 accordingly.
REQ-026 flush SHALL invalidate all entries at the next edge; dispatch, issue and wakeup in a flush cycle are discarded.
REQ-027 No issue while mdu_ready_i is 0; entries hold and continue to snoop the CDB.

Reset
REQ-028 While rst_n is low: all entries invalid, count_o = 0, disp_ready_o = 1, mdu_start_o = 0, all issue data outputs 0.
REQ-029 Reset assertion mid-operation discards all entries immediately, without waiting for a clock edge.

Structure
REQ-030 ALU_OP_* codes live in defines.v; ROB_ID_WIDTH and MDU_RS_DEPTH live in params.v; the block declares no local copies.
REQ-031 One sub-module, mdu_rs_pick (lowest-index-set priority picker, DEPTH-wide), is used for issue selection; all other logic stays in mdu_rs.

Verification
REQ-032 Dispatch MUL rob 3, vj=6, vk=7, no waits, mdu_ready_i=1 -> mdu_start_o=1 the next cycle with rs1=6, rs2=7, rob_id=3; count returns to 0.
REQ-033 Dispatch DIV rob 5 waiting on qj=2; CDB tag 2, value 100 two cycles later -> issue occurs exactly one cycle after the wakeup, with rs1=100.
REQ-034 Fill 4 entries, all waiting -> disp_ready_o=0, and a 5th disp_valid_i is ignored; wake entry 2 -> it issues before older still-waiting entries 0 and 1, and the queue collapses.
REQ-035 Dispatch with qk=7 while the CDB broadcasts tag 7, value 0xDEAD in the same cycle -> entry stored ready with rs2=0xDEAD.
REQ-036 mdu_ready_i=0 for 10 cycles with 2 ready entries -> no start; on release, the oldest issues first.
REQ-037 Assert flush with 3 valid entries plus a concurrent dispatch -> count_o=0 and no start next cycle; async rst_n pulse mid-cycle -> outputs zero before the next edge.

Source files
------------

// File: rtl/mdu_rs_pkg.sv
// Shared opcode/tag parameters and the reservation-station entry layout
// for the multiply/divide reservation station.
package mdu_rs_pkg;
  localparam int ROB_ID_WIDTH = 4;
  localparam int MDU_RS_DEPTH = 4;

  localparam logic [4:0] ALU_OP_MUL    = 5'd16;
  localparam logic [4:0] ALU_OP_MULH   = 5'd17;
  localparam logic [4:0] ALU_OP_MULHSU = 5'd18;
  localparam logic [4:0] ALU_OP_MULHU  = 5'd19;
  localparam logic [4:0] ALU_OP_DIV    = 5'd20;
  localparam logic [4:0] ALU_OP_DIVU   = 5'd21;
  localparam logic [4:0] ALU_OP_REM    = 5'd22;
  localparam logic [4:0] ALU_OP_REMU   = 5'd23;

  typedef struct packed {
    logic                    valid;
    logic [4:0]              op;
    logic [ROB_ID_WIDTH-1:0] rob;
    logic [31:0]             vj;
    logic [31:0]             vk;
    logic                    qj_wait;
    logic                    qk_wait;
    logic [ROB_ID_WIDTH-1:0] qj;
    logic [ROB_ID_WIDTH-1:0] qk;
  } rs_entry_t;
endpackage

// File: rtl/mdu_rs_pick.sv
// Lowest-index-set priority picker: one-hot grant plus encoded index.
module mdu_rs_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // Scan downward so the lowest set bit is the last one to win.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = ($clog2(N))'(i);
        any    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mdu_rs.sv
// Collapsing age-ordered reservation station feeding the MDU; entry 0 is
// oldest, the oldest ready entry issues, CDB snooping wakes operands.
module mdu_rs
  import mdu_rs_pkg::*;
#(
  parameter int DEPTH = MDU_RS_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    disp_valid_i,
  input  logic [4:0]              disp_op_i,
  input  logic [ROB_ID_WIDTH-1:0] disp_rob_id_i,
  input  logic [31:0]             disp_vj_i,
  input  logic [31:0]             disp_vk_i,
  input  logic                    disp_qj_wait_i,
  input  logic                    disp_qk_wait_i,
  input  logic [ROB_ID_WIDTH-1:0] disp_qj_i,
  input  logic [ROB_ID_WIDTH-1:0] disp_qk_i,
  output logic                    disp_ready_o,
  input  logic                    cdb_valid_i,
  input  logic [ROB_ID_WIDTH-1:0] cdb_rob_id_i,
  input  logic [31:0]             cdb_value_i,
  output logic                    mdu_start_o,
  output logic [4:0]              mdu_op_o,
  output logic [31:0]             mdu_rs1_o,
  output logic [31:0]             mdu_rs2_o,
  output logic [ROB_ID_WIDTH-1:0] mdu_rob_id_o,
  input  logic                    mdu_ready_i,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);

  rs_entry_t [DEPTH-1:0] ent_q, ent_w, ent_d;
  rs_entry_t             dent;
  logic [CW-1:0]         cnt_q, cnt_d, slot;
  logic [DEPTH-1:0]      rdy, pick_gnt;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any, issue, accept, sh;

  assign disp_ready_o = cnt_q < CW'(DEPTH);
  assign accept       = disp_valid_i && disp_ready_o && !flush;
  assign issue        = mdu_ready_i && !flush && pick_any;

  // Readiness uses pre-wakeup state so a woken entry waits one cycle.
  always_comb begin
    ent_w = ent_q;
    rdy   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = ent_q[i].valid && !ent_q[i].qj_wait && !ent_q[i].qk_wait;
      if (cdb_valid_i && ent_q[i].valid && ent_q[i].qj_wait && ent_q[i].qj == cdb_rob_id_i) begin
        ent_w[i].vj      = cdb_value_i;
        ent_w[i].qj_wait = 1'b0;
      end
      if (cdb_valid_i && ent_q[i].valid && ent_q[i].qk_wait && ent_q[i].qk == cdb_rob_id_i) begin
        ent_w[i].vk      = cdb_value_i;
        ent_w[i].qk_wait = 1'b0;
      end
    end
  end

  mdu_rs_pick #(.N(DEPTH)) u_pick (
    .req (rdy),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    dent         = '0;
    dent.valid   = 1'b1;
    dent.op      = disp_op_i;
    dent.rob     = disp_rob_id_i;
    dent.vj      = disp_vj_i;
    dent.vk      = disp_vk_i;
    dent.qj_wait = disp_qj_wait_i;
    dent.qk_wait = disp_qk_wait_i;
    dent.qj      = disp_qj_i;
    dent.qk      = disp_qk_i;
    if (cdb_valid_i && disp_qj_wait_i && disp_qj_i == cdb_rob_id_i) begin
      dent.vj      = cdb_value_i;
      dent.qj_wait = 1'b0;
    end
    if (cdb_valid_i && disp_qk_wait_i && disp_qk_i == cdb_rob_id_i) begin
      dent.vk      = cdb_value_i;
      dent.qk_wait = 1'b0;
    end
  end

  // Collapse above the issued slot, then append dispatch at the new tail.
  always_comb begin
    ent_d = ent_w;
    sh    = 1'b0;
    if (issue) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        sh = sh | pick_gnt[i];
        if (sh) ent_d[i] = ent_w[i+1];
      end
      ent_d[DEPTH-1] = '0;
    end
    slot  = cnt_q - CW'(issue);
    cnt_d = slot;
    if (accept) begin
      for (int i = 0; i < DEPTH; i++)
        if (slot == CW'(i)) ent_d[i] = dent;
      cnt_d = slot + CW'(1);
    end
    if (flush) begin
      ent_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  assign count_o      = cnt_q;
  assign mdu_start_o  = issue;
  assign mdu_op_o     = issue ? ent_q[pick_idx].op  : '0;
  assign mdu_rs1_o    = issue ? ent_q[pick_idx].vj  : '0;
  assign mdu_rs2_o    = issue ? ent_q[pick_idx].vk  : '0;
  assign mdu_rob_id_o = issue ? ent_q[pick_idx].rob : '0;
endmodule

// File: tb/tb_mdu_rs.sv
// Scoreboard bench for mdu_rs: a queue-level reference model predicts each
// cycle's issue and occupancy; a monitor compares the DUT's issue port.
module tb_mdu_rs;
  import mdu_rs_pkg::*;
  localparam int DEPTH = MDU_RS_DEPTH;
  localparam int RW    = ROB_ID_WIDTH;

  logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic          disp_valid_i = 1'b0, disp_qj_wait_i = 1'b0, disp_qk_wait_i = 1'b0;
  logic [4:0]    disp_op_i = '0;
  logic [RW-1:0] disp_rob_id_i = '0, disp_qj_i = '0, disp_qk_i = '0;
  logic [31:0]   disp_vj_i = '0, disp_vk_i = '0;
  logic          disp_ready_o;
  logic          cdb_valid_i = 1'b0;
  logic [RW-1:0] cdb_rob_id_i = '0;
  logic [31:0]   cdb_value_i = '0;
  logic          mdu_start_o, mdu_ready_i = 1'b1;
  logic [4:0]    mdu_op_o;
  logic [31:0]   mdu_rs1_o, mdu_rs2_o;
  logic [RW-1:0] mdu_rob_id_o;
  logic [$clog2(DEPTH):0] count_o;

  always #5 clk = ~clk;

  mdu_rs #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid_i(disp_valid_i), .disp_op_i(disp_op_i), .disp_rob_id_i(disp_rob_id_i),
    .disp_vj_i(disp_vj_i), .disp_vk_i(disp_vk_i),
    .disp_qj_wait_i(disp_qj_wait_i), .disp_qk_wait_i(disp_qk_wait_i),
    .disp_qj_i(disp_qj_i), .disp_qk_i(disp_qk_i), .disp_ready_o(disp_ready_o),
    .cdb_valid_i(cdb_valid_i), .cdb_rob_id_i(cdb_rob_id_i), .cdb_value_i(cdb_value_i),
    .mdu_start_o(mdu_start_o), .mdu_op_o(mdu_op_o), .mdu_rs1_o(mdu_rs1_o),
    .mdu_rs2_o(mdu_rs2_o), .mdu_rob_id_o(mdu_rob_id_o), .mdu_ready_i(mdu_ready_i),
    .count_o(count_o)
  );

  typedef struct {
    logic [4:0] op; logic [RW-1:0] rob; logic [31:0] vj, vk;
    bit wj, wk; logic [RW-1:0] qj, qk;
  } m_ent_t;
  typedef struct { logic [4:0] op; logic [31:0] rs1, rs2; logic [RW-1:0] rob; } iss_t;

  m_ent_t mq[$];
  iss_t   exp_q[$];
  int     checks = 0, failures = 0;

  function automatic void chk(string nm, logic [127:0] a, logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endfunction

  // Reference model: evaluated mid-cycle on stable inputs, then advanced to
  // the state the next rising edge should produce.
  int     k, sz;
  m_ent_t ne;
  iss_t   ie;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("count", 128'(count_o), 128'(mq.size()));
      chk("disp_ready", 128'(disp_ready_o), 128'(mq.size() < DEPTH));
      k  = -1;
      sz = mq.size();
      if (mdu_ready_i && !flush)
        for (int i = 0; i < mq.size(); i++)
          if (!mq[i].wj && !mq[i].wk) begin k = i; break; end
      if (k >= 0) begin
        ie.op = mq[k].op; ie.rs1 = mq[k].vj; ie.rs2 = mq[k].vk; ie.rob = mq[k].rob;
        exp_q.push_back(ie);
      end
      if (flush) mq.delete();
      else begin
        if (k >= 0) mq.delete(k);
        for (int i = 0; i < mq.size(); i++) begin
          if (cdb_valid_i && mq[i].wj && mq[i].qj == cdb_rob_id_i) begin mq[i].vj = cdb_value_i; mq[i].wj = 0; end
          if (cdb_valid_i && mq[i].wk && mq[i].qk == cdb_rob_id_i) begin mq[i].vk = cdb_value_i; mq[i].wk = 0; end
        end
        if (disp_valid_i && sz < DEPTH) begin
          ne.op = disp_op_i; ne.rob = disp_rob_id_i; ne.vj = disp_vj_i; ne.vk = disp_vk_i;
          ne.wj = disp_qj_wait_i; ne.wk = disp_qk_wait_i; ne.qj = disp_qj_i; ne.qk = disp_qk_i;
          if (cdb_valid_i && ne.wj && ne.qj == cdb_rob_id_i) begin ne.vj = cdb_value_i; ne.wj = 0; end
          if (cdb_valid_i && ne.wk && ne.qk == cdb_rob_id_i) begin ne.vk = cdb_value_i; ne.wk = 0; end
          mq.push_back(ne);
        end
      end
    end
  end

  iss_t got;
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      chk("start", 128'(mdu_start_o), 128'(exp_q.size() > 0));
      if (mdu_start_o && exp_q.size() > 0) begin
        got = exp_q.pop_front();
        chk("issue_op", 128'(mdu_op_o), 128'(got.op));
        chk("issue_rs1", 128'(mdu_rs1_o), 128'(got.rs1));
        chk("issue_rs2", 128'(mdu_rs2_o), 128'(got.rs2));
        chk("issue_rob", 128'(mdu_rob_id_o), 128'(got.rob));
      end else if (!mdu_start_o) begin
        chk("idle_zero", 128'({mdu_op_o, mdu_rs1_o, mdu_rs2_o, mdu_rob_id_o}), 128'(0));
      end
      exp_q.delete();
    end
  end

  task automatic step(); @(posedge clk); #1; endtask

  task automatic idle();
    disp_valid_i = 0; disp_qj_wait_i = 0; disp_qk_wait_i = 0; cdb_valid_i = 0; flush = 0;
  endtask

  task automatic disp(input logic [4:0] op, input logic [RW-1:0] rob, input logic [31:0] vj, vk,
                      input bit wj, input logic [RW-1:0] qj, input bit wk, input logic [RW-1:0] qk);
    disp_valid_i = 1; disp_op_i = op; disp_rob_id_i = rob; disp_vj_i = vj; disp_vk_i = vk;
    disp_qj_wait_i = wj; disp_qj_i = qj; disp_qk_wait_i = wk; disp_qk_i = qk;
  endtask

  task automatic cdb(input logic [RW-1:0] tag, input logic [31:0] val);
    cdb_valid_i = 1; cdb_rob_id_i = tag; cdb_value_i = val;
  endtask

  initial begin
    #12;
    chk("rst_count", 128'(count_o), 128'(0));
    chk("rst_ready", 128'(disp_ready_o), 128'(1));
    chk("rst_start", 128'(mdu_start_o), 128'(0));
    chk("rst_data", 128'({mdu_op_o, mdu_rs1_o, mdu_rs2_o, mdu_rob_id_o}), 128'(0));
    step(); rst_n = 1; step();

    // Basic back-to-back MUL
    disp(ALU_OP_MUL, 3, 6, 7, 0, 0, 0, 0); step(); idle();
    chk("t032_start", 128'(mdu_start_o), 128'(1));
    chk("t032_rob", 128'(mdu_rob_id_o), 128'(3));
    step(); chk("t032_count", 128'(count_o), 128'(0));

    // Wakeup via CDB, issue one cycle later
    disp(ALU_OP_DIV, 5, 0, 9, 1, 2, 0, 0); step(); idle(); step();
    cdb(2, 100); step(); idle();
    chk("t033_start", 128'(mdu_start_o), 128'(1));
    chk("t033_rs1", 128'(mdu_rs1_o), 128'(100));
    step();

    // Fill with waiting entries, ignored 5th, wake middle entry
    for (int i = 0; i < DEPTH; i++) begin
      disp(ALU_OP_REM, RW'(i), 0, 1, 1, RW'(8 + i), 0, 0); step();
    end
    disp(ALU_OP_MUL, 15, 1, 1, 0, 0, 0, 0);
    chk("t034_full", 128'(disp_ready_o), 128'(0));
    step(); idle();
    cdb(10, 32'h55); step(); idle();
    chk("t034_rob", 128'(mdu_rob_id_o), 128'(2));
    step(); chk("t034_count", 128'(count_o), 128'(DEPTH - 1));
    for (int i = 0; i < DEPTH; i++) begin cdb(RW'(8 + i), 32'(i)); step(); end
    idle(); step(); step();

    // Dispatch-cycle bypass
    disp(ALU_OP_MULHU, 4, 1, 0, 0, 0, 1, 7); cdb(7, 32'hDEAD); step(); idle();
    chk("t035_rs2", 128'(mdu_rs2_o), 128'(32'hDEAD));
    step();

    // Back-pressure hold
    mdu_ready_i = 0;
    disp(ALU_OP_DIVU, 1, 11, 12, 0, 0, 0, 0); step();
    disp(ALU_OP_REMU, 2, 13, 14, 0, 0, 0, 0); step(); idle();
    for (int i = 0; i < 10; i++) step();
    mdu_ready_i = 1; #1;
    chk("t036_oldest", 128'(mdu_rob_id_o), 128'(1));
    step(); step();

    // Flush with concurrent dispatch
    mdu_ready_i = 0;
    for (int i = 0; i < 3; i++) begin disp(ALU_OP_MUL, RW'(i), 1, 2, 0, 0, 0, 0); step(); end
    flush = 1; disp(ALU_OP_MUL, 9, 1, 2, 0, 0, 0, 0); step(); idle(); mdu_ready_i = 1; #1;
    chk("t037_flush_count", 128'(count_o), 128'(0));
    chk("t037_flush_start", 128'(mdu_start_o), 128'(0));
    step();

    // Asynchronous reset pulse mid-cycle
    mdu_ready_i = 0;
    disp(ALU_OP_MULH, 6, 1, 2, 0, 0, 0, 0); step();
    disp(ALU_OP_MULH, 7, 3, 4, 0, 0, 0, 0); step(); idle();
    mdu_ready_i = 1; #1;
    rst_n = 0; mq.delete(); exp_q.delete(); #1;
    chk("t037_rst_count", 128'(count_o), 128'(0));
    chk("t037_rst_ready", 128'(disp_ready_o), 128'(1));
    chk("t037_rst_out", 128'({mdu_start_o, mdu_op_o, mdu_rs1_o, mdu_rs2_o, mdu_rob_id_o}), 128'(0));
    rst_n = 1;
    step(); step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      disp_valid_i   = ($urandom_range(0, 1) == 1);
      disp_op_i      = 5'(ALU_OP_MUL + 5'($urandom_range(0, 7)));
      disp_rob_id_i  = RW'($urandom);
      disp_vj_i      = $urandom; disp_vk_i = $urandom;
      disp_qj_wait_i = ($urandom_range(0, 1) == 1); disp_qj_i = RW'($urandom);
      disp_qk_wait_i = ($urandom_range(0, 2) == 0); disp_qk_i = RW'($urandom);
      cdb_valid_i    = ($urandom_range(0, 9) < 5); cdb_rob_id_i = RW'($urandom); cdb_value_i = $urandom;
      mdu_ready_i    = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 63) == 0);
      step();
    end
    idle(); mdu_ready_i = 1; step(); step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
